// File: rtl/ifu_burst_bridge.sv
// I-cache line-fill bridge: turns single-cycle burst requests into AXI4 INCR reads and forwards returned beats.
// Optional performance counters are enabled by defining IFU_BRIDGE_PERF_EN.
module ifu_burst_bridge #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_len,
  input  logic        mem_cancel,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic        mem_rlast,
  output logic        bus_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [3:0]  arid,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid
`ifdef IFU_BRIDGE_PERF_EN
  ,
  output logic [31:0] perf_burst_cnt,
  output logic [31:0] perf_beat_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]  state;
  logic        drop;
  logic        pend_vld;
  logic [31:0] pend_addr;
  logic [7:0]  pend_len;
  logic        busy;
  logic        cancel_now;
  logic        beat;
  logic        beat_ok;
  logic        beat_fwd;

  assign arid    = AXI_ID;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign rready  = (state == DATA);

  assign busy       = (state != IDLE);
  assign cancel_now = mem_cancel && busy;
  assign beat       = rvalid && rready;
  assign beat_ok    = (rid == AXI_ID);
  // A cancel seen in the same cycle as a beat already suppresses that beat.
  assign beat_fwd   = beat && beat_ok && !drop && !cancel_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      drop       <= 1'b0;
      pend_vld   <= 1'b0;
      bus_err    <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_rlast  <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= beat_fwd;
      if (beat_fwd) begin
        mem_rdata <= rdata;
        mem_rlast <= rlast;
      end
      if (beat && (rresp != 2'b00 || !beat_ok))
        bus_err <= 1'b1;
      if (cancel_now)
        drop <= 1'b1;
      if (mem_req && busy)
        pend_vld <= 1'b1;

      case (state)
        IDLE: begin
          if (mem_req) begin
            araddr  <= mem_addr;
            arlen   <= mem_len;
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (beat && rlast) begin
            drop <= 1'b0;
            // A request arriving with rlast is newer than the pending one and wins.
            if (mem_req) begin
              araddr   <= mem_addr;
              arlen    <= mem_len;
              arvalid  <= 1'b1;
              pend_vld <= 1'b0;
              state    <= ADDR;
            end else if (pend_vld) begin
              araddr   <= pend_addr;
              arlen    <= pend_len;
              arvalid  <= 1'b1;
              pend_vld <= 1'b0;
              state    <= ADDR;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          arvalid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_req && busy) begin
      pend_addr <= mem_addr;
      pend_len  <= mem_len;
    end
  end

`ifdef IFU_BRIDGE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_burst_cnt <= '0;
      perf_beat_cnt  <= '0;
    end else begin
      if (arvalid && arready)
        perf_burst_cnt <= perf_burst_cnt + 32'd1;
      if (beat_fwd)
        perf_beat_cnt <= perf_beat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_burst_bridge.sv
// Scoreboard bench for ifu_burst_bridge: directed scenarios followed by randomized traffic against a transaction-level model.
module tb_ifu_burst_bridge;
  localparam logic [3:0] ID = 4'h5;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_cancel;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;
  logic        bus_err;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [3:0]  arid;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
`ifdef IFU_BRIDGE_PERF_EN
  logic [31:0] perf_burst_cnt;
  logic [31:0] perf_beat_cnt;
`endif

  ifu_burst_bridge #(.AXI_ID(ID)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len), .mem_cancel(mem_cancel),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast), .bus_err(bus_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
`ifdef IFU_BRIDGE_PERF_EN
    , .perf_burst_cnt(perf_burst_cnt), .perf_beat_cnt(perf_beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_mon = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one burst in flight, one pending slot, drop flag per burst.
  typedef struct { logic [31:0] a; logic [7:0] l; } ar_t;
  typedef struct { logic [31:0] d; logic l; } bt_t;
  ar_t ar_q[$];
  bt_t exp_q[$];
  bit          busy, ar_out, drop_m, pend_v, exp_err, fwd_prev, last_l;
  logic [31:0] pend_a, last_d;
  logic [7:0]  pend_l;
  int          n_burst_m, n_beat_m;

  task automatic issue(input logic [31:0] a, input logic [7:0] l);
    ar_t e;
    e.a = a;
    e.l = l;
    busy = 1;
    ar_out = 1;
    ar_q.push_back(e);
  endtask

  always @(negedge clk) begin
    bit dp, bad;
    bt_t b;
    if (rst) begin
      busy = 0; ar_out = 0; drop_m = 0; pend_v = 0; exp_err = 0; fwd_prev = 0;
      last_d = '0; last_l = 0; n_burst_m = 0; n_beat_m = 0;
      ar_q.delete();
      exp_q.delete();
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_mem_rvalid", mem_rvalid, 0);
      chk("rst_mem_rlast", mem_rlast, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arlen", arlen, 0);
      chk("rst_mem_rdata", mem_rdata, 0);
    end else begin
      chk("arvalid", arvalid, ar_out);
      if (ar_out && ar_q.size() > 0) begin
        chk("araddr", araddr, ar_q[0].a);
        chk("arlen", arlen, ar_q[0].l);
        chk("arid", arid, ID);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
      end
      dp = busy && !ar_out;
      chk("rready", rready, dp);
      chk("mem_rvalid", mem_rvalid, fwd_prev);
      if (!fwd_prev) begin
        chk("mem_rdata_hold", mem_rdata, last_d);
        chk("mem_rlast_hold", mem_rlast, last_l);
      end
      chk("bus_err", bus_err, exp_err);

      if (ar_out && arready) begin
        ar_out = 0;
        void'(ar_q.pop_front());
        n_burst_m++;
      end
      if (mem_cancel && busy) drop_m = 1;
      if (mem_req) begin
        if (busy) begin
          pend_a = mem_addr; pend_l = mem_len; pend_v = 1;
        end else begin
          issue(mem_addr, mem_len);
        end
      end
      fwd_prev = 0;
      if (dp && rvalid) begin
        bad = (rid != ID);
        if (bad || rresp != 2'b00) exp_err = 1;
        if (!drop_m && !bad) begin
          b.d = rdata;
          b.l = rlast;
          exp_q.push_back(b);
          fwd_prev = 1; last_d = rdata; last_l = rlast;
          n_beat_m++;
        end
        if (rlast) begin
          busy = 0;
          drop_m = 0;
          if (pend_v) begin
            pend_v = 0;
            issue(pend_a, pend_l);
          end
        end
      end
    end
  end

  // Monitor: every forwarded beat must match the oldest expected beat.
  always @(negedge clk) begin
    bt_t e;
    if (!rst && mem_rvalid) begin
      n_mon++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data %0h with nothing expected", mem_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", mem_rdata, e.d);
        chk("beat_last", mem_rlast, e.l);
      end
    end
  end

  // AXI read slave
  int   s_q[$];
  int   bi;
  bit   r_gap = 0;
  int   err_mode = 0;
  bit   ar_block = 0;
  bit   ar_rand = 0;

  initial begin
    bit s_acc, s_hs, s_rst;
    logic [7:0] s_len;
    rvalid = 0; rdata = '0; rresp = 2'b00; rlast = 0; rid = ID; bi = 0;
    forever begin
      @(negedge clk);
      s_acc = rvalid && rready;
      s_hs  = arvalid && arready;
      s_len = arlen;
      s_rst = rst;
      @(posedge clk);
      #2;
      if (s_rst || rst) begin
        s_q.delete(); bi = 0; rvalid = 0;
      end else begin
        if (s_acc && s_q.size() > 0) begin
          if (bi >= s_q[0]) begin
            void'(s_q.pop_front());
            bi = 0;
          end else bi++;
        end
        if (s_hs) s_q.push_back(int'(s_len));
        if (rvalid && !s_acc) begin
          rvalid = 1;
        end else if (s_q.size() > 0 && (!r_gap || $urandom_range(3, 0) != 0)) begin
          rvalid = 1;
          rdata  = $urandom;
          rlast  = (bi == s_q[0]);
          rresp  = 2'b00;
          rid    = ID;
          if (err_mode == 1 && $urandom_range(15, 0) == 0) rresp = 2'b10;
          if (err_mode == 1 && $urandom_range(15, 0) == 0) rid = ID ^ 4'h1;
          if (err_mode == 2 && bi == 2) rresp = 2'b10;
        end else begin
          rvalid = 0;
        end
      end
    end
  end

  initial begin
    arready = 0;
    forever begin
      @(posedge clk);
      #2;
      if (ar_block) arready = 0;
      else arready = ar_rand ? ($urandom_range(2, 0) != 0) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] a, input logic [7:0] l);
    mem_req = 1; mem_addr = a; mem_len = l;
    tick();
    mem_req = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(busy == 0 && pend_v == 0 && exp_q.size() == 0) && n < 2000);
    n_cmp++;
    if (n >= 2000) begin
      n_err++;
      $display("FAIL %s_timeout: still busy after %0d cycles, %0d beats owed", nm, n, exp_q.size());
    end
  endtask

  task automatic wait_beats(input string nm, input int target);
    int n;
    n = 0;
    while (n_beat_m < target && n < 500) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= 500) begin
      n_err++;
      $display("FAIL %s_timeout: saw %0d beats, needed %0d", nm, n_beat_m, target);
    end
  endtask

  initial begin
    int base;
    rst = 1; mem_req = 0; mem_addr = '0; mem_len = '0; mem_cancel = 0;
    repeat (3) tick();

    // Request right at reset release, arready high, back-to-back beats.
    rst = 0;
    send_req(32'h3000_0040, 8'd3);
    wait_idle("basic");

    // AR stalled five cycles.
    ar_block = 1;
    send_req(32'h3000_1000, 8'd1);
    repeat (5) tick();
    ar_block = 0;
    wait_idle("ar_stall");

    // Cancel after beat 1, new request on the following cycle.
    base = n_mon;
    send_req(32'h3000_0000, 8'd3);
    wait_beats("cancel", n_beat_m + 2);
    mem_cancel = 1;
    tick();
    mem_cancel = 0;
    send_req(32'h3000_0080, 8'd3);
    wait_idle("cancel");
    chk("cancel_fwd_beats", n_mon - base, 6);

    // Error response on beat 2 is sticky across a clean burst.
    err_mode = 2;
    send_req(32'h3000_0100, 8'd3);
    wait_idle("err");
    chk("bus_err_set", bus_err, 1);
    err_mode = 0;
    send_req(32'h3000_0140, 8'd3);
    wait_idle("err_after");
    chk("bus_err_sticky", bus_err, 1);

    // Reset pulse in the middle of a burst.
    send_req(32'h3000_0200, 8'd7);
    wait_beats("midrst", n_beat_m + 2);
    rst = 1;
    tick();
    base = n_mon;
    rst = 0;
    repeat (6) tick();
    chk("no_beats_after_rst", n_mon - base, 0);
    chk("bus_err_cleared", bus_err, 0);

    // Randomized traffic with pending requests, cancels, stalls and errors.
    r_gap = 1; ar_rand = 1; err_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      mem_req    = ($urandom_range(7, 0) == 0);
      mem_addr   = {$urandom_range(32'h03FF_FFFF, 0), 6'b0};
      mem_len    = 8'($urandom_range(5, 0));
      mem_cancel = ($urandom_range(24, 0) == 0);
      tick();
    end
    mem_req = 0; mem_cancel = 0;
    wait_idle("random");
    repeat (2) tick();
`ifdef IFU_BRIDGE_PERF_EN
    chk("perf_burst_cnt", perf_burst_cnt, n_burst_m);
    chk("perf_beat_cnt", perf_beat_cnt, n_beat_m);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_burst_bridge.md
IFU_BURST_BRIDGE -- requirements
Module: ifu_burst_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0, fixed ARID driven on every read.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_req  input  1  single-cycle burst request pulse from the I-cache.
REQ-005 mem_addr  input  32  line-aligned start address, sampled with mem_req.
REQ-006 mem_len  input  8  beats minus one, sampled with mem_req.
REQ-007 mem_cancel  input  1  cache flush; abandons the burst in flight.
REQ-008 mem_rvalid  output  1  returned beat valid (registered).
REQ-009 mem_rdata  output  32  returned beat data (registered).
REQ-010 mem_rlast  output  1  last beat of the burst (registered).
REQ-011 bus_err  output  1  sticky; set on any non-OKAY RRESP.
REQ-012 arvalid/arready  output/input  1/1  AXI4 AR handshake.
REQ-013 araddr  output  32; arlen  output  8; arid  output  4.
REQ-014 arsize  output  3  constant 3'b010; arburst  output  2  constant 2'b01 (INCR).
REQ-015 rvalid/rready  input/output  1/1; rdata  input  32; rresp  input  2; rlast  input  1; rid  input  4.

Function
REQ-016 SHALL implement states IDLE, ADDR, DATA.
REQ-017 IDLE: mem_req -> latch addr/len into araddr/arlen, assert arvalid, go ADDR next cycle.
REQ-018 ADDR: arvalid held with araddr/arlen stable until arready; on arvalid&&arready -> arvalid=0, go DATA.
REQ-019 DATA: rready=1; each rvalid&&rready beat appears on mem_rvalid/mem_rdata/mem_rlast exactly one cycle later.
REQ-020 DATA: beat with rlast=1 -> IDLE (or ADDR if a pending request exists, REQ-024).
REQ-021 rready SHALL be 0 in IDLE and ADDR.
REQ-022 mem_cancel in ADDR or DATA -> set drop flag; remaining beats of that burst accepted (rready=1) but NOT forwarded; AR handshake still completed; drop flag cleared at rlast.
REQ-023 mem_cancel in IDLE, or with no burst outstanding, SHALL have no effect.
REQ-024 mem_req while not IDLE -> capture into one-entry pending register; issued (ADDR) on the cycle after the current burst's rlast; a second req while pending full overwrites it.
REQ-025 mem_req and mem_cancel same cycle -> cancel applies only to the burst already outstanding; new request not dropped.
REQ-026 beat with rid != AXI_ID SHALL be accepted, not forwarded, and set bus_err.
REQ-027 rresp != 2'b00 -> bus_err=1 (sticky until reset); beat still forwarded unless dropped.
REQ-028 mem_rvalid SHALL be 0 in every cycle not following a forwarded beat; mem_rdata/mem_rlast hold last values.
REQ-029 Beat count SHALL not be checked against arlen; rlast alone terminates a burst.

Reset
REQ-030 rst asserted, any state (incl. mid-burst) -> IDLE; arvalid, rready, mem_rvalid, mem_rlast, bus_err, drop, pending-valid = 0; araddr, arlen, mem_rdata = 0.
REQ-031 After deassertion, first mem_req SHALL be sampled on the first rising edge.

Configuration
REQ-032 Macro IFU_BRIDGE_PERF_EN defined -> add outputs perf_burst_cnt (32, +1 per completed AR handshake) and perf_beat_cnt (32, +1 per forwarded beat), both reset 0, wrap at 2^32.
REQ-033 IFU_BRIDGE_PERF_EN undefined -> those ports and counters absent; all other behaviour identical.

Verification
REQ-034 mem_req addr=0x3000_0040 len=3, arready=1, 4 beats A0..A3 rlast on 4th -> araddr 0x3000_0040, arlen 3, mem_rvalid 4 cycles each 1 cycle after beat, mem_rlast with A3.
REQ-035 arready held 0 for 5 cycles -> arvalid/araddr/arlen stable all 5 cycles; single handshake.
REQ-036 mem_cancel after beat 1 of 4, new mem_req 0x3000_0080 next cycle -> beats 2-3 not forwarded; AR for 0x3000_0080 issued cycle after old rlast; its 4 beats forwarded.
REQ-037 beat 2 with rresp=2'b10 -> bus_err=1 and stays 1 through later OKAY bursts until rst.
REQ-038 rst pulse during DATA with rvalid=1 -> all outputs reset values next cycle; no mem_rvalid after.
REQ-039 With IFU_BRIDGE_PERF_EN: two 4-beat bursts, one cancelled after beat 0 -> perf_burst_cnt=2, perf_beat_cnt=5.
